// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache with single-block refill from instruction memory.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_controller #(
    parameter int NUM_SETS    = 8,
    parameter int ADDR_W      = 10,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          READ,
    input  logic [ADDR_W-1:0]             ADDRESS,
    output logic [31:0]                   INSTRUCTION,
    output logic                          BUSYWAIT,
    output logic                          MEM_READ,
    output logic [ADDR_W-5:0]             MEM_ADDRESS,
    input  logic [BLOCK_WORDS*32-1:0]     MEM_READDATA,
    input  logic                          MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                   HIT_COUNT,
    output logic [15:0]                   MISS_COUNT
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int BLK_W = ADDR_W - 4;
    localparam int TAG_W = BLK_W - IDX_W;

    typedef logic [BLOCK_WORDS-1:0][31:0] block_t;
    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

    state_t                state_q, state_d;
    logic [NUM_SETS-1:0]   valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    block_t                data_q [NUM_SETS];
    block_t                fill_q;
    logic [BLK_W-1:0]      miss_blk_q;
    logic [31:0]           instr_q;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [OFF_W-1:0]      req_off;
    logic                  hit;
    logic                  latch_miss;
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  unused_byte_bits;

    assign req_idx          = ADDRESS[4 +: IDX_W];
    assign req_tag          = ADDRESS[ADDR_W-1 -: TAG_W];
    assign req_off          = ADDRESS[2 +: OFF_W];
    assign unused_byte_bits = ^ADDRESS[1:0];

    assign fill_idx = miss_blk_q[IDX_W-1:0];
    assign fill_tag = miss_blk_q[BLK_W-1 -: TAG_W];

    assign hit         = READ & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    assign INSTRUCTION = hit ? data_q[req_idx][req_off] : instr_q;
    assign MEM_ADDRESS = miss_blk_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        BUSYWAIT   = 1'b0;
        MEM_READ   = 1'b0;
        latch_miss = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (READ && !hit) begin
                    BUSYWAIT   = 1'b1;
                    latch_miss = 1'b1;
                    state_d    = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                MEM_READ = 1'b1;
                BUSYWAIT = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                BUSYWAIT = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A cold cache would otherwise report a miss while reset is still held.
        if (RESET) begin
            BUSYWAIT = 1'b0;
            MEM_READ = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            miss_blk_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch_miss) begin
                miss_blk_q <= ADDRESS[ADDR_W-1:4];
            end
            if (state_q == S_UPDATE) begin
                valid_q[fill_idx] <= 1'b1;
            end
            if (hit) begin
                instr_q <= data_q[req_idx][req_off];
            end
        end
    end

    // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge CLK) begin
        if (state_q == S_MEM_READ && !MEM_BUSYWAIT) begin
            fill_q <= block_t'(MEM_READDATA);
        end
        if (state_q == S_UPDATE) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_q;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if (state_q == S_IDLE && hit && HIT_COUNT != 16'hFFFF) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end
            if (latch_miss && MISS_COUNT != 16'hFFFF) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
`else
    // Statistics build option disabled: no counters are instantiated.
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: a latency-programmable memory model plus a
// set-occupancy reference model predicts hit/miss, stall length and fetched words.
module tb_icache_controller;

    localparam int NUM_SETS = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic [9:0]   ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT = 1'b1;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT;
    logic [15:0]  MISS_COUNT;
`endif

    icache_controller dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [127:0] backing [64];
    int           mem_lat  = 5;
    int           mem_cnt  = 0;
    int           held [NUM_SETS];   // block number cached in each set, -1 when empty
    logic [31:0]  last_word = '0;

    // Instruction memory: data valid on the mem_lat-th cycle of a read request.
    always @(negedge CLK) begin
        if (MEM_READ === 1'b1) begin
            mem_cnt++;
            MEM_BUSYWAIT = (mem_cnt < mem_lat);
            MEM_READDATA = backing[MEM_ADDRESS];
        end else begin
            mem_cnt      = 0;
            MEM_BUSYWAIT = 1'b1;
            MEM_READDATA = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] word_of(input logic [9:0] a);
        logic [127:0] b;
        b = backing[a[9:4]];
        return b[32*a[3:2] +: 32];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_SETS; i++) held[i] = -1;
    endtask

    // Present one fetch and follow it until served; model decides hit/miss and stall length.
    task automatic fetch(input logic [9:0] addr, input string name);
        int blk, idx, exp_busy, busy;
        bit exp_hit, saw_rd, bad_addr;
        blk      = int'(addr[9:4]);
        idx      = blk % NUM_SETS;
        exp_hit  = (held[idx] == blk);
        exp_busy = exp_hit ? 0 : mem_lat + 2;
        busy     = 0;
        saw_rd   = 0;
        bad_addr = 0;
        @(negedge CLK);
        ADDRESS = addr;
        READ    = 1'b1;
        #1;
        while (BUSYWAIT === 1'b1 && busy < 100) begin
            if (MEM_READ === 1'b1) begin
                saw_rd = 1;
                if (MEM_ADDRESS !== 6'(blk)) bad_addr = 1;
            end
            busy++;
            @(negedge CLK);
            #1;
        end
        n_checks++;
        if (busy !== exp_busy) $display("FAIL %s stall_cycles: got %0d want %0d", name, busy, exp_busy);
        else n_pass++;
        n_checks++;
        if (INSTRUCTION !== word_of(addr))
            $display("FAIL %s instruction @%h: got %h want %h", name, addr, INSTRUCTION, word_of(addr));
        else n_pass++;
        n_checks++;
        if (saw_rd !== !exp_hit) $display("FAIL %s mem_read_seen: got %0b want %0b", name, saw_rd, !exp_hit);
        else n_pass++;
        n_checks++;
        if (bad_addr) $display("FAIL %s mem_address: got wrong block want %h", name, 6'(blk));
        else n_pass++;
        held[idx] = blk;
        last_word = word_of(addr);
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        READ    = 1'b0;
        ADDRESS = '0;
        repeat (2) @(negedge CLK);
        READ = 1'b1;
        #1;
        n_checks++;
        if (BUSYWAIT !== 1'b0) $display("FAIL reset busywait: got %b want 0", BUSYWAIT); else n_pass++;
        n_checks++;
        if (MEM_READ !== 1'b0) $display("FAIL reset mem_read: got %b want 0", MEM_READ); else n_pass++;
        n_checks++;
        if (INSTRUCTION !== 32'h0) $display("FAIL reset instruction: got %h want 0", INSTRUCTION); else n_pass++;
`ifdef ICACHE_STATS_EN
        n_checks++;
        if (HIT_COUNT !== 16'h0 || MISS_COUNT !== 16'h0)
            $display("FAIL reset counters: got %h/%h want 0/0", HIT_COUNT, MISS_COUNT);
        else n_pass++;
`endif
        @(negedge CLK);
        RESET = 1'b0;
        READ  = 1'b0;
        clear_model();
    endtask

    task automatic test_cold_miss();
        mem_lat = 5;
        fetch(10'h000, "cold_miss");
        n_checks++;
        if (INSTRUCTION !== 32'h00000003) $display("FAIL cold_miss word0: got %h want 00000003", INSTRUCTION);
        else n_pass++;
    endtask

    task automatic test_seq_hits();
        fetch(10'h004, "seq_hit4");
        fetch(10'h008, "seq_hit8");
        fetch(10'h00C, "seq_hitC");
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        @(negedge CLK);
        READ = 1'b0;
        #1;
        n_checks++;
        if (MISS_COUNT !== 16'd1) $display("FAIL stats miss_count: got %0d want 1", MISS_COUNT); else n_pass++;
        n_checks++;
        if (HIT_COUNT !== 16'd4) $display("FAIL stats hit_count: got %0d want 4", HIT_COUNT); else n_pass++;
    endtask
`endif

    task automatic test_conflict();
        mem_lat = 3;
        fetch(10'h080, "conflict_tag1");
        fetch(10'h000, "conflict_tag0");
        fetch(10'h084, "conflict_again");
    endtask

    task automatic test_reset_mid_refill();
        int w;
        mem_lat = 20;
        @(negedge CLK);
        ADDRESS = 10'h030;
        READ    = 1'b1;
        #1;
        w = 0;
        while (MEM_READ !== 1'b1 && w < 10) begin
            @(negedge CLK);
            #1;
            w++;
        end
        n_checks++;
        if (MEM_READ !== 1'b1) $display("FAIL midreset refill_start: got %b want 1", MEM_READ); else n_pass++;
        repeat (2) @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        n_checks++;
        if (MEM_READ !== 1'b0) $display("FAIL midreset mem_read: got %b want 0", MEM_READ); else n_pass++;
        n_checks++;
        if (BUSYWAIT !== 1'b0) $display("FAIL midreset busywait: got %b want 0", BUSYWAIT); else n_pass++;
        @(negedge CLK);
        RESET = 1'b0;
        READ  = 1'b0;
        clear_model();
        mem_lat = 2;
        fetch(10'h030, "midreset_refetch");
    endtask

    task automatic test_addr_change();
        int  w;
        bit  saw_two, bad;
        mem_lat = 4;
        @(negedge CLK);
        ADDRESS = 10'h010;
        READ    = 1'b1;
        #1;
        w = 0;
        while (MEM_READ !== 1'b1 && w < 10) begin
            @(negedge CLK);
            #1;
            w++;
        end
        n_checks++;
        if (MEM_ADDRESS !== 6'h01) $display("FAIL addrchg first_block: got %h want 01", MEM_ADDRESS); else n_pass++;
        @(negedge CLK);
        ADDRESS = 10'h020;
        #1;
        saw_two = 0;
        bad     = 0;
        w       = 0;
        while (BUSYWAIT === 1'b1 && w < 60) begin
            if (MEM_READ === 1'b1) begin
                if (MEM_ADDRESS === 6'h02) saw_two = 1;
                else if (MEM_ADDRESS !== 6'h01) bad = 1;
            end
            @(negedge CLK);
            #1;
            w++;
        end
        n_checks++;
        if (!saw_two || bad) $display("FAIL addrchg second_refill: got saw02=%0b stray=%0b want 1/0", saw_two, bad);
        else n_pass++;
        n_checks++;
        if (INSTRUCTION !== word_of(10'h020))
            $display("FAIL addrchg instruction: got %h want %h", INSTRUCTION, word_of(10'h020));
        else n_pass++;
        held[1]   = 1;
        held[2]   = 2;
        last_word = word_of(10'h020);
        fetch(10'h010, "addrchg_block1_kept");
    endtask

    task automatic test_random();
        logic [5:0] blk;
        logic [9:0] addr;
        for (int i = 0; i < 60; i++) begin
            mem_lat = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                READ = 1'b0;
                #1;
                n_checks++;
                if (BUSYWAIT !== 1'b0 || INSTRUCTION !== last_word)
                    $display("FAIL rand_idle: got busy=%b instr=%h want 0/%h", BUSYWAIT, INSTRUCTION, last_word);
                else n_pass++;
            end
            blk = 6'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) blk[5] = 1'b1;
            addr = {blk, 4'($urandom_range(0, 15))};
            fetch(addr, "rand_fetch");
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) backing[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        backing[0] = 128'h0000000C_00000008_00000004_00000003;
        clear_model();
        test_reset();
        test_cold_miss();
        test_seq_hits();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        test_conflict();
        test_reset_mid_refill();
        test_addr_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Direct-mapped, read-only instruction cache.
- Sits between the pc_unit fetch address and the instruction memory.
- Returns the 32-bit instruction on a hit in the same cycle.
- On a miss, asserts BUSYWAIT (drives the pc_unit STALL input), refills one block from instruction memory, then serves the fetch.

Parameters:
- NUM_SETS, 8, number of cache lines (power of two); index width = log2(NUM_SETS).
- ADDR_W, 10, byte address width of PC bits used; tag width = ADDR_W - 4 - log2(NUM_SETS).
- BLOCK_WORDS, 4, 32-bit words per block (fixed 4; block = 128 bits, mem block address = ADDR_W-4 bits).

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- READ  in  1  fetch request; high whenever the PC is valid.
- ADDRESS  in  ADDR_W  byte address of instruction (PC[ADDR_W-1:0]); bits [1:0] ignored.
- INSTRUCTION  out  32  fetched instruction word.
- BUSYWAIT  out  1  stall to pc_unit; high while the fetch is not yet served.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  ADDR_W-4  block address {tag,index} of the refill.
- MEM_READDATA  in  128  refill block; word0 in bits [31:0].
- MEM_BUSYWAIT  in  1  memory busy; data valid on the cycle it drops low.

Behaviour:
- Storage: per line valid bit, tag, 128-bit data. Address split: [3:2] word offset, [3+idx:4] index, upper bits tag.
- Hit = READ & valid[index] & (tag[index]==ADDRESS tag). Evaluated combinationally.
- INSTRUCTION = selected word of data[index] on hit; otherwise holds its last value.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - READ & hit: BUSYWAIT=0, stay in IDLE.
  - READ & miss: BUSYWAIT=1 in the same cycle. Latch the tag/index of ADDRESS into the miss register. Next state MEM_READ.
  - READ=0: BUSYWAIT=0, stay in IDLE.
- MEM_READ:
  - MEM_READ=1, MEM_ADDRESS = latched {tag,index}, BUSYWAIT=1.
  - On a rising edge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
- UPDATE (exactly 1 cycle):
  - Write data, tag, valid=1 into the latched index.
  - MEM_READ=0, BUSYWAIT=1. Next state IDLE.
  - The following cycle re-evaluates as a hit and deasserts BUSYWAIT.
- Miss penalty = memory latency + 2 cycles (MEM_READ entry, UPDATE).
- The refill always uses the latched miss address. ADDRESS changing during a miss (not expected while stalled) does not corrupt the refill. It is re-evaluated in IDLE.
- MEM_ADDRESS in states other than MEM_READ: the latched value, don't-care to memory.
- Reset (async, any state including mid-refill):
  - All valid bits cleared, FSM goes to IDLE.
  - MEM_READ=0, BUSYWAIT=0, INSTRUCTION=0, miss register=0.
  - Any in-flight memory response is ignored.
- After reset is released, the first fetch (PC=0) always misses.
- Replacement: direct-mapped overwrite. No write path, no dirty bits.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both cleared by RESET.
  - HIT_COUNT increments once per rising edge in IDLE with READ & hit & pc-advance (BUSYWAIT=0).
  - MISS_COUNT increments once per IDLE->MEM_READ transition.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: RESET pulse, ADDRESS=0, READ=1; memory returns 128'h0000000C_00000008_00000004_00000003 after 5 busy cycles.
  - Required: BUSYWAIT high 7 cycles, MEM_ADDRESS=0. Then INSTRUCTION=32'h00000003, BUSYWAIT=0.
- Sequential hits: ADDRESS=4, 8, 12 after the above -> no MEM_READ; INSTRUCTION=4, 8, 0xC each in the same cycle, BUSYWAIT=0.
- Conflict miss:
  - Stimulus: ADDRESS=0x080 (same index 0, tag 1), then ADDRESS=0x000.
  - Required: both miss; MEM_ADDRESS=0x08 then 0x00; the line is overwritten each time.
- Reset mid-refill:
  - Stimulus: assert RESET asynchronously while in MEM_READ with MEM_BUSYWAIT=1.
  - Required: MEM_READ and BUSYWAIT drop immediately without a clock edge. The next fetch of the same address misses again.
- Address change during stall: change ADDRESS from 0x010 to 0x020 while in MEM_READ -> refill block 0x01 is written; 0x020 then misses and refills 0x02.
- With ICACHE_STATS_EN: run the first two scenarios -> MISS_COUNT=1, HIT_COUNT=4.
